// File: rtl/alu64_pkg.sv
// Shared width constant and operation encoding for the 64-bit ALU.
package alu64_pkg;

    localparam int unsigned ALU_W = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_NOR = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice: full add (with b inverted for SUB) or NOR/XOR.
module alu1bit
    import alu64_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_e op,
    output logic    s,
    output logic    cout
);

    logic bx;

    always_comb begin
        bx   = (op == ALU_SUB) ? ~b : b;
        s    = 1'b0;
        cout = 1'b0;
        unique case (op)
            ALU_ADD, ALU_SUB: begin
                s    = a ^ bx ^ cin;
                cout = (a & bx) | (cin & (a ^ bx));
            end
            ALU_NOR: s = ~(a | b);
            ALU_XOR: s = a ^ b;
            default: s = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_64bit.sv
// Registered 64-bit ripple-carry ALU built from alu1bit slices.
// Optional signed-overflow output enabled by defining ALU64_OVF_EN.
module alu_64bit
    import alu64_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [ALU_W-1:0] s,
    output logic             cout
`ifdef ALU64_OVF_EN
    ,
    output logic             ovf
`endif
);

    alu_op_e          op_e;
    logic [ALU_W:0]   c;
    logic [ALU_W-1:0] s_d, s_q;
    logic             cout_d, cout_q;

    assign op_e = alu_op_e'(op);
    assign c[0] = cin;

    for (genvar i = 0; i < ALU_W; i++) begin : g_slice
        alu1bit u_slice (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .op   (op_e),
            .s    (s_d[i]),
            .cout (c[i+1])
        );
    end

    assign cout_d = c[ALU_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

`ifdef ALU64_OVF_EN
    logic ovf_d, ovf_q;

    // Logic ops zero every slice carry, so this term is already 0 for NOR/XOR.
    assign ovf_d = c[ALU_W-1] ^ c[ALU_W];

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_64bit.sv
// Scoreboard testbench for alu_64bit: driver pushes model results, monitor pops one per edge.
module tb_alu_64bit;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a, b;
    logic        cin;
    logic [1:0]  op;
    logic [63:0] s;
    logic        cout;
`ifdef ALU64_OVF_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    alu_64bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .op   (op),
        .s    (s),
        .cout (cout)
`ifdef ALU64_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic r, input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic [1:0] o, input string nm);
        exp_t        e;
        logic [64:0] full;
        logic [63:0] yy;
        e.name = nm;
        e.s = '0; e.cout = 1'b0; e.ovf = 1'b0;
        if (r) return e;
        case (o)
            2'd0, 2'd1: begin
                yy     = (o == 2'd1) ? ~y : y;
                full   = {1'b0, x} + {1'b0, yy} + {64'd0, ci};
                e.s    = full[63:0];
                e.cout = full[64];
                e.ovf  = (x[63] == yy[63]) && (e.s[63] != x[63]);
            end
            2'd2: e.s = ~(x | y);
            default: e.s = x ^ y;
        endcase
        return e;
    endfunction

    task automatic apply(input logic r, input logic [63:0] x, input logic [63:0] y,
                         input logic ci, input logic [1:0] o, input string nm);
        rst = r; a = x; b = y; cin = ci; op = o;
        sb.push_back(model(r, x, y, ci, o, nm));
        @(negedge clk);
    endtask

    // Monitor: every edge produces one result, matched in order against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (s !== e.s) begin
                    errors++;
                    $display("FAIL %s s: got %h expected %h", e.name, s, e.s);
                end
                checks++;
                if (cout !== e.cout) begin
                    errors++;
                    $display("FAIL %s cout: got %b expected %b", e.name, cout, e.cout);
                end
`ifdef ALU64_OVF_EN
                checks++;
                if (ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL %s ovf: got %b expected %b", e.name, ovf, e.ovf);
                end
`endif
            end
        end
    end

    initial begin
        logic [63:0] ra, rb;
        int          wait_cycles;

        apply(1'b1, 64'h1234, 64'h5678, 1'b1, 2'd0, "reset0");
        apply(1'b1, '1, '1, 1'b1, 2'd1, "reset1");

        apply(1'b0, '1, '0, 1'b0, 2'd0, "ripple_cin0");
        apply(1'b0, '1, '0, 1'b1, 2'd0, "ripple_cin1");

        apply(1'b0, 64'd5, 64'd3, 1'b1, 2'd1, "sub_5_3");
        apply(1'b0, 64'd3, 64'd5, 1'b1, 2'd1, "sub_3_5");

        apply(1'b0, '0, '0, 1'b1, 2'd2, "nor_zero");
        apply(1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_0000_0000, 1'b1, 2'd3, "xor_pat");

        apply(1'b0, 64'd1, 64'd1, 1'b0, 2'd0, "add_1_1");
        apply(1'b1, 64'd1, 64'd1, 1'b0, 2'd0, "mid_reset");
        apply(1'b0, 64'd1, 64'd1, 1'b0, 2'd0, "after_reset");

        apply(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'd0, "ovf_add");
        apply(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'd3, "ovf_xor");
        apply(1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 2'd1, "ovf_sub");

        apply(1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0, 2'd0, "b2b_add");
        apply(1'b0, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b1, 2'd1, "b2b_sub");
        apply(1'b0, 64'hAAAA_5555_AAAA_5555, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 2'd2, "b2b_nor");
        apply(1'b0, 64'h1111_2222_3333_4444, 64'hFFFF_0000_FFFF_0000, 1'b1, 2'd3, "b2b_xor");

        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 16 == 0) rb = ~ra;
            apply((i % 53) == 52, ra, rb, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), "random");
        end

        rst = 1'b1;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 5) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
